// File: rtl/dadz_seq.sv
// dadz_seq: sequencer for the sigmoid-derivative term used in backpropagation.
// Streams activations a (signed Q8.24, 1.0 = 32'h01000000) from an activation RAM.
// Each one goes through a shared pipeline that computes a*(a-1.0).
// Each result is written to a result RAM at wr_base + element index.
// One instance is time-shared across all neurons of a layer.
//
// Optional build macro DADZ_SEQ_ERR_MUL_EN:
//   Adds a stage that multiplies each result by err_data.
//   Write latency grows from 3 to 4 cycles after the read.
//   Start-to-done time grows from L+4 to L+5.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   start                 one-cycle request, sampled only in IDLE and only when not held
//   len                   element count, 0 selects HiddenNeuron
//   rd_base, wr_base      first activation / result address
//   hold                  freezes all state; rd_en and wr_en read low while held
//   rd_en, rd_addr        activation/error RAM read port
//   rd_data, err_data     read data, valid one cycle after rd_en
//   wr_en, wr_addr, wr_data  result RAM write port
//   busy, done            busy from ISSUE through FIN, done pulses once in FIN
module dadz_seq #(
    parameter int unsigned DWIDTH       = 32,
    parameter int unsigned AWIDTH       = 10,
    parameter int unsigned HiddenNeuron = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH:0]   len,
    input  logic [AWIDTH-1:0] rd_base,
    input  logic [AWIDTH-1:0] wr_base,
    input  logic              hold,
    output logic              rd_en,
    output logic [AWIDTH-1:0] rd_addr,
    input  logic [DWIDTH-1:0] rd_data,
    input  logic [DWIDTH-1:0] err_data,
    output logic              wr_en,
    output logic [AWIDTH-1:0] wr_addr,
    output logic [DWIDTH-1:0] wr_data,
    output logic              busy,
    output logic              done
);
    localparam int unsigned       FRAC    = 24;
    localparam logic [DWIDTH-1:0] ONE     = DWIDTH'(1) << FRAC;
    localparam logic [AWIDTH:0]   DEF_LEN = (AWIDTH+1)'(HiddenNeuron);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFin} state_e;

    state_e                   state_q;
    logic [AWIDTH:0]          rem_q;      // reads still to issue, including the current one
    logic                     rd_en_q;
    logic                     wr_en_q;
    logic                     rv_q;       // rd_data holds a requested activation
    logic                     s1_v_q;
    logic signed [DWIDTH-1:0] s1_a_q;
    logic signed [DWIDTH-1:0] s1_t_q;
    logic [AWIDTH-1:0]        wr_ptr_q;   // address of the next result to leave the pipeline
    logic signed [2*DWIDTH-1:0] mul_at;
    logic [DWIDTH-1:0]        p_d;
    logic                     pipe_busy;

    // Held cycles must not strobe either RAM; the registered strobes are kept for release.
    assign rd_en = rd_en_q & ~hold;
    assign wr_en = wr_en_q & ~hold;

    assign mul_at = (2*DWIDTH)'(s1_a_q) * (2*DWIDTH)'(s1_t_q);
    assign p_d    = DWIDTH'(mul_at >>> FRAC);

`ifdef DADZ_SEQ_ERR_MUL_EN
    logic signed [DWIDTH-1:0]   s1_e_q;
    logic signed [DWIDTH-1:0]   s2_p_q;
    logic signed [DWIDTH-1:0]   s2_e_q;
    logic                       s2_v_q;
    logic signed [2*DWIDTH-1:0] mul_pe;

    assign mul_pe    = (2*DWIDTH)'(s2_p_q) * (2*DWIDTH)'(s2_e_q);
    // The output stage empties on the same edge that moves the FSM to FIN.
    assign pipe_busy = rv_q | s1_v_q | s2_v_q;
`else
    logic unused_err;
    assign unused_err = ^err_data;
    assign pipe_busy  = rv_q | s1_v_q;
`endif

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            rd_en_q <= 1'b0;
            rd_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (!hold) begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        rem_q   <= (len == '0) ? DEF_LEN : len;
                        rd_addr <= rd_base;
                        rd_en_q <= 1'b1;
                        busy    <= 1'b1;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (rem_q == (AWIDTH+1)'(1)) begin
                        rem_q   <= '0;
                        rd_en_q <= 1'b0;
                        state_q <= StDrain;
                    end else begin
                        rem_q   <= rem_q - (AWIDTH+1)'(1);
                        rd_addr <= rd_addr + AWIDTH'(1);
                    end
                end
                StDrain: begin
                    if (!pipe_busy) begin
                        done    <= 1'b1;
                        state_q <= StFin;
                    end
                end
                StFin: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Datapath pipeline; the final stage doubles as the write-port register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv_q     <= 1'b0;
            s1_v_q   <= 1'b0;
            s1_a_q   <= '0;
            s1_t_q   <= '0;
            wr_ptr_q <= '0;
            wr_en_q  <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
`ifdef DADZ_SEQ_ERR_MUL_EN
            s1_e_q   <= '0;
            s2_v_q   <= 1'b0;
            s2_p_q   <= '0;
            s2_e_q   <= '0;
`endif
        end else if (!hold) begin
            rv_q   <= rd_en_q;
            s1_v_q <= rv_q;
            if (rv_q) begin
                s1_a_q <= rd_data;
                s1_t_q <= rd_data - ONE;
`ifdef DADZ_SEQ_ERR_MUL_EN
                s1_e_q <= err_data;
`endif
            end
            // Pipeline is empty in IDLE, so loading never collides with an increment.
            if (state_q == StIdle && start) begin
                wr_ptr_q <= wr_base;
            end
`ifdef DADZ_SEQ_ERR_MUL_EN
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_p_q <= p_d;
                s2_e_q <= s1_e_q;
            end
            wr_en_q <= s2_v_q;
            if (s2_v_q) begin
                wr_data  <= DWIDTH'(mul_pe >>> FRAC);
                wr_addr  <= wr_ptr_q;
                wr_ptr_q <= wr_ptr_q + AWIDTH'(1);
            end
`else
            wr_en_q <= s1_v_q;
            if (s1_v_q) begin
                wr_data  <= p_d;
                wr_addr  <= wr_ptr_q;
                wr_ptr_q <= wr_ptr_q + AWIDTH'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_dadz_seq.sv
// Self-checking bench for dadz_seq.
// Expected reads and writes are queued when a vector is started.
// A negedge monitor pops them as the DUT strobes rd_en / wr_en.
module tb_dadz_seq;
    localparam int AW = 10;
    localparam int DW = 32;
`ifdef DADZ_SEQ_ERR_MUL_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          start    = 1'b0;
    logic          hold     = 1'b0;
    logic [AW:0]   len      = '0;
    logic [AW-1:0] rd_base  = '0;
    logic [AW-1:0] wr_base  = '0;
    logic [DW-1:0] rd_data  = '0;
    logic [DW-1:0] err_data = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;

    dadz_seq #(.DWIDTH(DW), .AWIDTH(AW), .HiddenNeuron(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .rd_base  (rd_base),
        .wr_base  (wr_base),
        .hold     (hold),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .err_data (err_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // RAM model: one-cycle read latency, output stable when not strobed.
    logic [DW-1:0] act_mem [1024];
    logic [DW-1:0] err_mem [1024];
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data  <= act_mem[rd_addr];
            err_data <= err_mem[rd_addr];
        end
    end

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_wr_q [$];
    logic [AW-1:0] exp_rd_q [$];
    int            rd_stamp_q [$];
    wr_t           e_wr;
    int cyc = 0, held = 0, rd_cnt = 0, done_cnt = 0, done_cyc = 0, st_cyc = 0;
    int n_cmp = 0, n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] q_mul(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] prod;
        prod = 64'(longint'($signed(x)) * longint'($signed(y)));
        return prod[55:24];
    endfunction

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] e);
        logic [31:0] t;
        logic [31:0] p;
        t = a - 32'h01000000;
        p = q_mul(a, t);
`ifdef DADZ_SEQ_ERR_MUL_EN
        return q_mul(p, e);
`else
        return p;
`endif
    endfunction

    // Monitor: every held cycle extends the read-to-write distance by exactly one.
    always @(negedge clk) begin
        if (!rst) begin
            if (hold) begin
                held++;
                check("rd_en_in_hold", 64'(rd_en), 64'd0);
                check("wr_en_in_hold", 64'(wr_en), 64'd0);
            end
            if (rd_en) begin
                rd_cnt++;
                check("rd_expected", 64'(exp_rd_q.size() != 0), 64'd1);
                if (exp_rd_q.size() != 0) check("rd_addr", 64'(rd_addr), 64'(exp_rd_q.pop_front()));
                rd_stamp_q.push_back(cyc - held);
            end
            if (wr_en) begin
                check("wr_expected", 64'(exp_wr_q.size() != 0), 64'd1);
                if (exp_wr_q.size() != 0) begin
                    e_wr = exp_wr_q.pop_front();
                    check("wr_addr", 64'(wr_addr), 64'(e_wr.addr));
                    check("wr_data", 64'(wr_data), 64'(e_wr.data));
                end
                if (rd_stamp_q.size() != 0)
                    check("wr_latency", 64'(cyc - held - rd_stamp_q.pop_front()), 64'(LAT));
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_wr_q.push_back(w);
    endtask

    task automatic expect_vec(input int n, input logic [AW-1:0] rb, input logic [AW-1:0] wb);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] ra;
            ra = rb + AW'(i);
            exp_rd_q.push_back(ra);
            push_wr(wb + AW'(i), model(act_mem[ra], err_mem[ra]));
        end
    endtask

    task automatic start_vec(input logic [AW:0] l, input logic [AW-1:0] rb, input logic [AW-1:0] wb);
        @(negedge clk);
        len     = l;
        rd_base = rb;
        wr_base = wb;
        start   = 1'b1;
        st_cyc  = cyc;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input int dur);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check("done_seen", 64'(done_cnt - d0), 64'd1);
        check("start_to_done", 64'(done_cyc - st_cyc), 64'(dur));
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic wait_reads(input int r0, input int n);
        int k;
        k = 0;
        while (rd_cnt - r0 < n && k < 200) begin
            @(posedge clk);
            k++;
        end
        check("reads_reached", 64'(rd_cnt - r0), 64'(n));
    endtask

    initial begin
        int r0;
        int d0;
        for (int i = 0; i < 1024; i++) begin
            act_mem[i] = '0;
            err_mem[i] = 32'h01000000;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("wr_en_post_rst", 64'(wr_en), 64'd0);

        // Single element: 0.5*(0.5-1) = -0.25 (scaled by err 2.0 -> -0.5 when enabled)
        act_mem[5] = 32'h00800000;
        err_mem[5] = 32'h02000000;
        exp_rd_q.push_back(10'd5);
`ifdef DADZ_SEQ_ERR_MUL_EN
        push_wr(10'd9, 32'hFF800000);
`else
        push_wr(10'd9, 32'hFFC00000);
`endif
        start_vec(11'd1, 10'd5, 10'd9);
        wait_done(1 + LAT + 1);

        // Boundary values 1.0, 0, 0.25
        act_mem[100] = 32'h01000000;
        act_mem[101] = 32'h00000000;
        act_mem[102] = 32'h00400000;
        for (int i = 0; i < 3; i++) exp_rd_q.push_back(AW'(100 + i));
        push_wr(10'd200, 32'h00000000);
        push_wr(10'd201, 32'h00000000);
        push_wr(10'd202, 32'hFFD00000);
        start_vec(11'd3, 10'd100, 10'd200);
        wait_done(3 + LAT + 1);

        // Default length with address wrap; include the most negative activation
        for (int i = 0; i < 16; i++) act_mem[(1020 + i) % 1024] = $urandom;
        act_mem[1020] = 32'h80000000;
        expect_vec(16, 10'd1020, 10'd1020);
        start_vec(11'd0, 10'd1020, 10'd1020);
        wait_done(16 + LAT + 1);

        // Hold for 3 cycles after the 4th read, with start pulses while busy
        for (int i = 0; i < 8; i++) begin
            act_mem[300 + i] = $urandom;
            err_mem[300 + i] = $urandom;
        end
        expect_vec(8, 10'd300, 10'd40);
        r0 = rd_cnt;
        start_vec(11'd8, 10'd300, 10'd40);
        wait_reads(r0, 4);
        #1;
        hold    = 1'b1;
        start   = 1'b1;
        len     = 11'd5;
        rd_base = 10'd0;
        wr_base = 10'd0;
        repeat (3) @(posedge clk);
        #1 hold = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_done(8 + LAT + 1 + 3);

        // Start while held in IDLE is ignored
        d0 = done_cnt;
        @(negedge clk);
        hold  = 1'b1;
        start = 1'b1;
        len   = 11'd4;
        @(negedge clk);
        start = 1'b0;
        hold  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_hold_busy", 64'(busy), 64'd0);
        end
        check("idle_hold_done", 64'(done_cnt - d0), 64'd0);

        // Reset during ISSUE, then a clean short vector
        for (int i = 0; i < 8; i++) act_mem[500 + i] = $urandom;
        expect_vec(8, 10'd500, 10'd600);
        r0 = rd_cnt;
        start_vec(11'd8, 10'd500, 10'd600);
        wait_reads(r0, 3);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_rd_en", 64'(rd_en), 64'd0);
        check("mid_rst_wr_en", 64'(wr_en), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_rd_addr", 64'(rd_addr), 64'd0);
        check("mid_rst_wr_addr", 64'(wr_addr), 64'd0);
        check("mid_rst_wr_data", 64'(wr_data), 64'd0);
        exp_rd_q.delete();
        exp_wr_q.delete();
        rd_stamp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_wr_en", 64'(wr_en), 64'd0);
        check("post_rst_rd_en", 64'(rd_en), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 2; i++) act_mem[700 + i] = $urandom;
        expect_vec(2, 10'd700, 10'd710);
        start_vec(11'd2, 10'd700, 10'd710);
        wait_done(2 + LAT + 1);

        repeat (5) @(negedge clk);
        check("writes_left", 64'(exp_wr_q.size()), 64'd0);
        check("reads_left", 64'(exp_rd_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
